// File: rtl/bcd_if.sv
// rtl/bcd_if.sv - binary input and decimal digit outputs of the bcd converter
interface bcd_if;
    logic [31:0] bin;
    logic [31:0] units;
    logic [31:0] tens;
    logic [31:0] hundreds;
    logic [31:0] thousands;

    // Producer of the binary value, consumer of the digits
    modport master (
        output bin,
        input  units,
        input  tens,
        input  hundreds,
        input  thousands
    );

    // The converter itself
    modport slave (
        input  bin,
        output units,
        output tens,
        output hundreds,
        output thousands
    );
endinterface

// File: rtl/bcd.sv
// rtl/bcd.sv - free-running 32-bit binary to BCD converter, exports low four digits
module bcd (
    input  logic clk,
    input  logic rst_n,
    bcd_if.slave bus
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] shreg;
    logic [31:0] shreg_next;
    logic [39:0] scratch;
    logic [39:0] scratch_next;
    logic [39:0] scratch_adj;
    logic [5:0]  cnt;
    logic [5:0]  cnt_next;

    logic [3:0]  dig_units;
    logic [3:0]  dig_tens;
    logic [3:0]  dig_hundreds;
    logic [3:0]  dig_thousands;
    logic [3:0]  dig_units_next;
    logic [3:0]  dig_tens_next;
    logic [3:0]  dig_hundreds_next;
    logic [3:0]  dig_thousands_next;

    // Top scratch bit is shifted out and discarded; a 32-bit value never reaches it
    logic        unused_scratch_msb;
    assign unused_scratch_msb = scratch_adj[39];

    // Add-3 correction: every digit >= 5 is bumped so the following shift carries into the next digit
    always_comb begin
        scratch_adj = scratch;
        for (int d = 0; d < 10; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath update for the LOAD / SHIFT / UPDATE sequence
    always_comb begin
        state_next         = state;
        shreg_next         = shreg;
        scratch_next       = scratch;
        cnt_next           = cnt;
        dig_units_next     = dig_units;
        dig_tens_next      = dig_tens;
        dig_hundreds_next  = dig_hundreds;
        dig_thousands_next = dig_thousands;

        case (state)
            LOAD: begin
                shreg_next   = bus.bin;
                scratch_next = '0;
                cnt_next     = '0;
                state_next   = SHIFT;
            end

            SHIFT: begin
                scratch_next = {scratch_adj[38:0], shreg[31]};
                shreg_next   = {shreg[30:0], 1'b0};
                cnt_next     = cnt + 6'd1;
                if (cnt == 6'd31) begin
                    state_next = UPDATE;
                end
            end

            UPDATE: begin
                dig_units_next     = scratch[3:0];
                dig_tens_next      = scratch[7:4];
                dig_hundreds_next  = scratch[11:8];
                dig_thousands_next = scratch[15:12];
                state_next         = LOAD;
            end

            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Conversion working registers: shift register, BCD scratch and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
        end else begin
            shreg   <= shreg_next;
            scratch <= scratch_next;
            cnt     <= cnt_next;
        end
    end

    // Exported digits only move on UPDATE, so a partial conversion is never visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_units     <= '0;
            dig_tens      <= '0;
            dig_hundreds  <= '0;
            dig_thousands <= '0;
        end else begin
            dig_units     <= dig_units_next;
            dig_tens      <= dig_tens_next;
            dig_hundreds  <= dig_hundreds_next;
            dig_thousands <= dig_thousands_next;
        end
    end

    assign bus.units     = {28'd0, dig_units};
    assign bus.tens      = {28'd0, dig_tens};
    assign bus.hundreds  = {28'd0, dig_hundreds};
    assign bus.thousands = {28'd0, dig_thousands};

endmodule

// File: tb/tb_bcd.sv
// tb/tb_bcd.sv - self-checking bench for the bcd converter
module tb_bcd;

    logic clk;
    logic rst_n;
    bcd_if bus ();

    bcd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] bin;
        logic [3:0]  th;
        logic [3:0]  hu;
        logic [3:0]  te;
        logic [3:0]  un;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [127:0] observed();
        return {bus.thousands, bus.hundreds, bus.tens, bus.units};
    endfunction

    function automatic logic [127:0] pack_digits(input logic [3:0] th, input logic [3:0] hu,
                                                 input logic [3:0] te, input logic [3:0] un);
        return {28'd0, th, 28'd0, hu, 28'd0, te, 28'd0, un};
    endfunction

    // Reference: plain decimal arithmetic on the value
    function automatic logic [127:0] model(input logic [31:0] v);
        logic [31:0] th;
        logic [31:0] hu;
        logic [31:0] te;
        logic [31:0] un;
        un = v % 32'd10;
        te = (v / 32'd10) % 32'd10;
        hu = (v / 32'd100) % 32'd10;
        th = (v / 32'd1000) % 32'd10;
        return {th, hu, te, un};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge just before a LOAD edge; leaves the bench at the negedge after UPDATE
    task automatic run_period(input logic [31:0] v);
        bus.bin = v;
        repeat (34) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{32'd1234,       4'd1, 4'd2, 4'd3, 4'd4};
        vecs[1]  = '{32'd0,          4'd0, 4'd0, 4'd0, 4'd0};
        vecs[2]  = '{32'd9999,       4'd9, 4'd9, 4'd9, 4'd9};
        vecs[3]  = '{32'd10000,      4'd0, 4'd0, 4'd0, 4'd0};
        vecs[4]  = '{32'hFFFFFFFF,   4'd7, 4'd2, 4'd9, 4'd5};
        vecs[5]  = '{32'd42,         4'd0, 4'd0, 4'd4, 4'd2};
        vecs[6]  = '{32'd5678,       4'd5, 4'd6, 4'd7, 4'd8};
        vecs[7]  = '{32'd12345,      4'd2, 4'd3, 4'd4, 4'd5};
        vecs[8]  = '{32'd1000,       4'd1, 4'd0, 4'd0, 4'd0};
        vecs[9]  = '{32'd9,          4'd0, 4'd0, 4'd0, 4'd9};
        vecs[10] = '{32'd99999999,   4'd9, 4'd9, 4'd9, 4'd9};
        vecs[11] = '{32'd2147483648, 4'd3, 4'd6, 4'd4, 4'd8};

        rst_n   = 1'b0;
        bus.bin = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", observed(), '0);

        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_period(vecs[i].bin);
            check($sformatf("vec%0d_bin%0d", i, vecs[i].bin), observed(),
                  pack_digits(vecs[i].th, vecs[i].hu, vecs[i].te, vecs[i].un));
        end

        // Input changed mid-SHIFT: current period keeps old value, next one picks up the new
        bus.bin = 32'd1234;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.bin = 32'd5678;
        repeat (24) @(posedge clk);
        @(negedge clk);
        check("midchange_old", observed(), pack_digits(4'd1, 4'd2, 4'd3, 4'd4));
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c < 34)
                check($sformatf("midchange_hold_c%0d", c), observed(), pack_digits(4'd1, 4'd2, 4'd3, 4'd4));
            else
                check("midchange_new", observed(), pack_digits(4'd5, 4'd6, 4'd7, 4'd8));
        end

        // Reset asserted mid-SHIFT clears outputs without a clock edge
        run_period(32'd1234);
        check("prereset_1234", observed(), pack_digits(4'd1, 4'd2, 4'd3, 4'd4));
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", observed(), '0);
        bus.bin = 32'd42;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (33) @(posedge clk);
        @(negedge clk);
        check("after_reset_still0", observed(), '0);
        @(posedge clk);
        @(negedge clk);
        check("after_reset_42", observed(), pack_digits(4'd0, 4'd0, 4'd4, 4'd2));

        // Boundary sweep around the mod-10000 wrap
        for (int v = 9990; v < 10010; v++) begin
            run_period(v[31:0]);
            check($sformatf("sweep_%0d", v), observed(), model(v[31:0]));
        end

        // Random values, small and full range
        for (int i = 0; i < 60; i++) begin
            logic [31:0] r;
            if (i % 2 == 0)
                r = $urandom_range(9999, 0);
            else
                r = $urandom;
            run_period(r);
            check($sformatf("rand%0d_bin%0d", i, r), observed(), model(r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
